// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// control words, stalls on MemReady and resolves beq/bne from the ALU Zero flag.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       Retire,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JAL    = 4'd10, S_JR    = 4'd11,
    S_IMMEX  = 4'd12, S_IMMWB  = 4'd13
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Everything is forced to zero while reset is held, including the debug state.
  always_comb begin
    state_d   = S_FETCH;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 2'b00;
    MemtoReg  = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    PCSrc     = 2'b00;
    Retire    = 1'b0;
    IllegalOp = 1'b0;
    State     = 4'd0;
    if (!rst) begin
      State = state_q;
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'b01;
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            6'h23, 6'h2B: state_d = S_MEMADR;
            6'h00:        state_d = (funct == 6'h08) ? S_JR : S_EXEC;
            6'h04, 6'h05: state_d = S_BRANCH;
            6'h02:        state_d = S_JUMP;
            6'h03:        state_d = S_JAL;
            6'h08, 6'h0D: state_d = S_IMMEX;
            default: begin
              IllegalOp = 1'b1;
              Retire    = 1'b1;
              state_d   = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = MemReady ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
          Retire   = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          Retire   = MemReady;
          state_d  = MemReady ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 2'b01;
          Retire   = 1'b1;
        end
        S_BRANCH: begin
          // opcode[0] distinguishes bne (taken on non-zero) from beq
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = 2'b01;
          PCWrite = opcode[0] ? ~Zero : Zero;
          Retire  = 1'b1;
        end
        S_JUMP: begin
          PCSrc   = 2'b10;
          PCWrite = 1'b1;
          Retire  = 1'b1;
        end
        S_JAL: begin
          PCSrc    = 2'b10;
          PCWrite  = 1'b1;
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
          Retire   = 1'b1;
        end
        S_JR: begin
          PCSrc   = 2'b11;
          PCWrite = 1'b1;
          Retire  = 1'b1;
        end
        S_IMMEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = (opcode == 6'h0D) ? 2'b11 : 2'b00;
          state_d = S_IMMWB;
        end
        S_IMMWB: begin
          RegWrite = 1'b1;
          Retire   = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl: one record per clock cycle with
// hand-computed control words, plus a hand-run sw sequence with a long memory stall.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, ALUOp, PCSrc;
  logic       ALUSrcA, Retire, IllegalOp;
  logic [3:0] State;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc), .Retire(Retire), .IllegalOp(IllegalOp),
    .State(State)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic        zero;
    logic        rdy;
    logic [22:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Packed control word: PCWrite IRWrite IorD MemRead MemWrite RegWrite RegDst
  // MemtoReg ALUSrcA ALUSrcB ALUOp PCSrc Retire IllegalOp State
  function automatic logic [22:0] ow(input logic pcw, input logic irw, input logic iord,
      input logic mr, input logic mw, input logic rw, input logic [1:0] rd,
      input logic [1:0] mtr, input logic sa, input logic [1:0] sb, input logic [1:0] op,
      input logic [1:0] pcs, input logic ret, input logic ill, input logic [3:0] st);
    return {pcw, irw, iord, mr, mw, rw, rd, mtr, sa, sb, op, pcs, ret, ill, st};
  endfunction

  function automatic logic [22:0] got_word();
    return {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
            ALUSrcA, ALUSrcB, ALUOp, PCSrc, Retire, IllegalOp, State};
  endfunction

  task automatic add(input logic r, input logic [5:0] opc, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [22:0] e, input string nm);
    vec_t v;
    v.rst = r; v.opc = opc; v.fn = fn; v.zero = z; v.rdy = rdy; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  logic [22:0] ZERO_W, F_RDY, F_WAIT, DEC;

  initial begin
    int cyc, rets, mw_cycles, waits;
    logic seen;
    rst = 1'b1; opcode = 6'h00; funct = 6'h00; Zero = 1'b0; MemReady = 1'b1;

    ZERO_W = ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'd0);
    F_RDY  = ow(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,4'd0);
    F_WAIT = ow(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'd0);
    DEC    = ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,4'd1);

    add(1'b1, 6'h00, 6'h00, 1'b0, 1'b1, ZERO_W, "reset0");
    add(1'b1, 6'h00, 6'h00, 1'b0, 1'b1, ZERO_W, "reset1");
    // lw
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, F_RDY, "lw_fetch");
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, DEC, "lw_decode");
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,4'd2), "lw_memadr");
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'd3), "lw_memrd");
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,4'd4), "lw_memwb");
    // addi with one fetch stall
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b0, F_WAIT, "addi_fetch_wait");
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, F_RDY, "addi_fetch");
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, DEC, "addi_decode");
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,4'd12), "addi_immex");
    add(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,4'd13), "addi_immwb");
    // sw with MemReady low for 2 cycles in MEMWR
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, F_RDY, "sw_fetch");
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, DEC, "sw_decode");
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,4'd2), "sw_memadr");
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, ow(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'd5), "sw_memwr_wait0");
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, ow(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'd5), "sw_memwr_wait1");
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,4'd5), "sw_memwr_done");
    // branches: beq/bne with Zero = 1 and 0
    for (int k = 0; k < 4; k++) begin
      logic [5:0] bop;
      logic       bz, taken;
      bop   = (k % 2 == 0) ? 6'h04 : 6'h05;
      bz    = (k < 2) ? 1'b1 : 1'b0;
      taken = (bop == 6'h04) ? bz : ~bz;
      add(1'b0, bop, 6'h00, bz, 1'b1, F_RDY, $sformatf("br%0d_fetch", k));
      add(1'b0, bop, 6'h00, bz, 1'b1, DEC, $sformatf("br%0d_decode", k));
      add(1'b0, bop, 6'h00, bz, 1'b1, ow(taken,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0,4'd8), $sformatf("br%0d_branch", k));
    end
    // R-type add
    add(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, F_RDY, "add_fetch");
    add(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, DEC, "add_decode");
    add(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,4'd6), "add_exec");
    add(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,4'd7), "add_aluwb");
    // jr
    add(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, F_RDY, "jr_fetch");
    add(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, DEC, "jr_decode");
    add(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, ow(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b11,1'b1,1'b0,4'd11), "jr_jr");
    // j
    add(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, F_RDY, "j_fetch");
    add(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, DEC, "j_decode");
    add(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, ow(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0,4'd9), "j_jump");
    // jal
    add(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, F_RDY, "jal_fetch");
    add(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, DEC, "jal_decode");
    add(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, ow(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0,4'd10), "jal_jal");
    // ori
    add(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, F_RDY, "ori_fetch");
    add(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, DEC, "ori_decode");
    add(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b11,2'b00,1'b0,1'b0,4'd12), "ori_immex");
    add(1'b0, 6'h0D, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,4'd13), "ori_immwb");
    // illegal opcode
    add(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, F_RDY, "ill_fetch");
    add(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,2'b00,2'b00,1'b1,1'b1,4'd1), "ill_decode");
    // lw aborted by a 3-cycle reset while stalled in MEMRD
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, F_RDY, "abort_fetch");
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, DEC, "abort_decode");
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, ow(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,4'd2), "abort_memadr");
    add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, ow(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,4'd3), "abort_memrd_wait");
    add(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, ZERO_W, "abort_rst0");
    add(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, ZERO_W, "abort_rst1");
    add(1'b1, 6'h23, 6'h00, 1'b0, 1'b1, ZERO_W, "abort_rst2");
    add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, F_WAIT, "after_rst_fetch");

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; opcode = vecs[i].opc; funct = vecs[i].fn;
      Zero = vecs[i].zero; MemReady = vecs[i].rdy;
      @(negedge clk);
      check(vecs[i].name, {9'd0, got_word()}, {9'd0, vecs[i].exp});
      @(posedge clk);
      #1;
    end

    // sw with a 3-cycle MEMWR stall: 7 cycles total, one Retire, MemWrite for 4 cycles
    opcode = 6'h2B; funct = 6'h00; rst = 1'b0;
    cyc = 0; rets = 0; mw_cycles = 0; waits = 0; seen = 1'b0;
    while (!seen && cyc < 30) begin
      if (State == 4'd5 && waits < 3) begin
        MemReady = 1'b0;
        waits++;
      end else begin
        MemReady = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (Retire)   begin rets++; seen = 1'b1; end
      if (MemWrite) mw_cycles++;
      @(posedge clk);
      #1;
    end
    check("sw_stall_cycles", cyc, 32'd7);
    check("sw_stall_retires", rets, 32'd1);
    check("sw_stall_memwrite_cycles", mw_cycles, 32'd4);
    check("sw_stall_back_to_fetch", {28'd0, State}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
